mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the core's read requesters and the commit store port.
- Read requesters: fetch slot 0, fetch slot 1, load 0, load 1.
- Issues at most one memory operation per cycle.
- Routes each read response back to its originating requester after a fixed memory latency.
- Sits between the IF/EX/commit memory bus signals and the physical memory macro.
- Drops in-flight read responses on a pipeline flush.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for fetch/load reads and the commit store port
// Optional feature macro: ARB_FAIRNESS_EN (bounds how long a stream of stores can starve reads)
module mem_port_arbiter #(
   parameter int NREQ       = 4,
   parameter int MEM_LAT    = 1,
`ifdef ARB_FAIRNESS_EN
   parameter int STARVE_MAX = 4,
`endif
   parameter int MODE_W     = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [NREQ-1:0]              rd_req_valid,
   output logic [NREQ-1:0]              rd_req_ready,
   input  logic [NREQ-1:0][31:0]        rd_req_addr,
   input  logic [NREQ-1:0][MODE_W-1:0]  rd_req_mode,
   output logic [NREQ-1:0]              rd_rsp_valid,
   output logic [NREQ-1:0][31:0]        rd_rsp_data,
   input  logic                         wr_req_valid,
   output logic                         wr_req_ready,
   input  logic [31:0]                  wr_req_addr,
   input  logic [31:0]                  wr_req_data,
   input  logic [MODE_W-1:0]            wr_req_mode,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [31:0]                  mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [MODE_W-1:0]            mem_mode,
   input  logic [31:0]                  mem_rdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]              rr_q, rr_d;
   logic [MEM_LAT-1:0]         tag_vld_q;
   logic [MEM_LAT-1:0][PW-1:0] tag_id_q;
   logic [PW-1:0]              rd_win;
   logic [PW-1:0]              cand_idx;
   logic                       rd_found;
   logic                       rd_pend;
   logic                       rd_any;
   logic                       rd_go;
   logic                       wr_go;
   logic                       force_rd;
   int                         cand;

   // Round-robin scan: first valid requester at or after rr_q, wrapping modulo NREQ
   always_comb begin
      rd_win   = rr_q;
      rd_found = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!rd_found) begin
            cand     = (int'(rr_q) + k) % NREQ;
            cand_idx = PW'(cand);
            if (rd_req_valid[cand_idx]) begin
               rd_found = 1'b1;
               rd_win   = cand_idx;
            end
         end
      end
   end

`ifdef ARB_FAIRNESS_EN
   logic [2:0] starve_q;

   // Count stores granted while reads wait; at the limit the read winner takes the next slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q <= '0;
      end else if (rd_go || !rd_pend) begin
         starve_q <= '0;
      end else if (wr_go && !flush) begin
         starve_q <= starve_q + 3'd1;
      end
   end

   assign force_rd = rd_any && (starve_q == 3'(STARVE_MAX));
`else
   assign force_rd = 1'b0;
`endif

   // Grants are held low during reset; flush blocks reads but never stores
   assign rd_pend = |rd_req_valid;
   assign rd_any  = rd_pend && !flush && reset;
   assign wr_go   = wr_req_valid && reset && !force_rd;
   assign rd_go   = rd_any && !wr_go;

   // Grant decode and memory macro drive for the single winner of this cycle
   always_comb begin
      rd_req_ready = '0;
      if (rd_go) begin
         rd_req_ready[rd_win] = 1'b1;
      end
      wr_req_ready = wr_go;
      mem_en       = rd_go || wr_go;
      mem_we       = wr_go;
      mem_addr     = wr_go ? wr_req_addr : rd_req_addr[rd_win];
      mem_mode     = wr_go ? wr_req_mode : rd_req_mode[rd_win];
      mem_wdata    = wr_req_data;
   end

   // Pointer moves past the granted reader only; write, idle and flush cycles keep it
   always_comb begin
      rr_d = rr_q;
      if (rd_go) begin
         rr_d = (rd_win == PW'(NREQ - 1)) ? '0 : rd_win + PW'(1);
      end
   end

   // Tag pipeline tracks which requester owns the data arriving MEM_LAT cycles after issue
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q      <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         rr_q         <= rr_d;
         tag_vld_q[0] <= rd_go;
         tag_id_q[0]  <= rd_win;
         for (int s = 1; s < MEM_LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1] && !flush;
            tag_id_q[s]  <= tag_id_q[s-1];
         end
      end
   end

   // Route the returning word to its owner; a flush suppresses the pulse in that cycle
   always_comb begin
      rd_rsp_valid = '0;
      rd_rsp_data  = '0;
      if (tag_vld_q[MEM_LAT-1] && !flush) begin
         rd_rsp_valid[tag_id_q[MEM_LAT-1]] = 1'b1;
         rd_rsp_data[tag_id_q[MEM_LAT-1]]  = mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int LAT = 3;

   typedef struct {
      int          port;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  flush;
   logic [3:0]            rd_req_valid;
   logic [3:0]            rd_req_ready;
   logic [3:0][31:0]      rd_req_addr;
   logic [3:0][2:0]       rd_req_mode;
   logic [3:0]            rd_rsp_valid;
   logic [3:0][31:0]      rd_rsp_data;
   logic                  wr_req_valid;
   logic                  wr_req_ready;
   logic [31:0]           wr_req_addr;
   logic [31:0]           wr_req_data;
   logic [2:0]            wr_req_mode;
   logic                  mem_en;
   logic                  mem_we;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [2:0]            mem_mode;
   logic [31:0]           mem_rdata;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb_q[$];

   logic [31:0] store_mem [logic [31:0]];
   logic [31:0] rpipe [LAT];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.NREQ(4), .MEM_LAT(LAT), .MODE_W(3)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_addr(rd_req_addr), .rd_req_mode(rd_req_mode),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
      .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_mode(wr_req_mode),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_rdata(mem_rdata)
   );

   // Memory model: unwritten words read back as addr+1, read data appears LAT cycles after issue
   assign mem_rdata = rpipe[LAT-1];
   always @(posedge clk) begin
      for (int s = LAT - 1; s > 0; s--) rpipe[s] <= rpipe[s-1];
      if (mem_en && !mem_we)
         rpipe[0] <= store_mem.exists(mem_addr) ? store_mem[mem_addr] : mem_addr + 32'd1;
      else
         rpipe[0] <= 32'h0BAD_0000;
      if (mem_en && mem_we) store_mem[mem_addr] = mem_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: every response pulse must match the oldest outstanding expectation, on its due cycle
   always @(negedge clk) begin
      #2;
      for (int p = 0; p < 4; p++) begin
         if (rd_rsp_valid[p] !== 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected port=%0d data=%h cyc=%0d required=no response", p, rd_rsp_data[p], cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (e.port != p || rd_rsp_data[p] !== e.data || cyc != e.due) begin
                  failures++;
                  $display("FAIL rsp actual port=%0d data=%h cyc=%0d required port=%0d data=%h cyc=%0d",
                           p, rd_rsp_data[p], cyc, e.port, e.data, e.due);
               end
            end
         end
      end
   end

   // Drive one cycle of requests, check the grant and memory drive, record the expected response
   task automatic step(input logic [3:0] rv, input logic wv, input logic fl,
                       input logic [3:0] e_rrdy, input logic e_wrdy,
                       input logic [31:0] e_addr, input logic [31:0] e_data,
                       input logic keep, input string nm);
      logic [2:0] e_mode;
      @(negedge clk);
      rd_req_valid = rv;
      wr_req_valid = wv;
      flush        = fl;
      #1;
      e_mode = 3'd7;
      for (int p = 0; p < 4; p++) if (e_rrdy[p]) e_mode = 3'(p);
      chk({nm, ".rd_ready"}, 32'(rd_req_ready), 32'(e_rrdy));
      chk({nm, ".wr_ready"}, 32'(wr_req_ready), 32'(e_wrdy));
      chk({nm, ".mem_en"}, 32'(mem_en), 32'(e_wrdy || (e_rrdy != 4'b0)));
      if (e_wrdy || (e_rrdy != 4'b0)) begin
         chk({nm, ".mem_we"}, 32'(mem_we), 32'(e_wrdy));
         chk({nm, ".mem_addr"}, mem_addr, e_addr);
         chk({nm, ".mem_mode"}, 32'(mem_mode), 32'(e_mode));
         if (e_wrdy) chk({nm, ".mem_wdata"}, mem_wdata, wr_req_data);
      end
      for (int p = 0; p < 4; p++) begin
         if (e_rrdy[p] && keep) begin
            exp_t e;
            e.port = p;
            e.data = e_data;
            e.due  = cyc + LAT;
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, "idle");
   endtask

   task automatic reset_checks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         chk("rst.rd_ready", 32'(rd_req_ready), 32'h0);
         chk("rst.wr_ready", 32'(wr_req_ready), 32'h0);
         chk("rst.mem_en", 32'(mem_en), 32'h0);
         chk("rst.mem_we", 32'(mem_we), 32'h0);
         chk("rst.rsp_valid", 32'(rd_rsp_valid), 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      reset        = 1'b0;
      flush        = 1'b0;
      rd_req_valid = 4'b1111;
      wr_req_valid = 1'b1;
      for (int p = 0; p < 4; p++) begin
         rd_req_addr[p] = 32'h40 + 32'(4 * p);
         rd_req_mode[p] = 3'(p);
      end
      wr_req_addr = 32'h100;
      wr_req_data = 32'hDEAD_BEEF;
      wr_req_mode = 3'd7;

      // Reset held with every request active
      reset_checks(3);
      @(negedge clk);
      rd_req_valid = 4'b0000;
      wr_req_valid = 1'b0;
      reset        = 1'b1;

      // Round-robin across all four readers, including the wrap back to port 0
      step(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h40, 32'h41, 1'b1, "rr0");
      step(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h44, 32'h45, 1'b1, "rr1");
      step(4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h48, 32'h49, 1'b1, "rr2");
      step(4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h4C, 32'h4D, 1'b1, "rr3");
      step(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h40, 32'h41, 1'b1, "rr_wrap");
      idle(LAT + 1);

      // Store beats a pending read, then the read goes next; read back the stored word
      step(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h100, 32'h0, 1'b0, "wr_prio");
      step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h48, 32'h49, 1'b1, "rd_after_wr");
      rd_req_addr[3] = 32'h100;
      step(4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, "rd_back");
      idle(LAT + 1);

      // Flush one cycle after a read issue, with a store in the flush cycle
      step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h44, 32'h0, 1'b0, "fl_rd");
      wr_req_addr = 32'h200;
      wr_req_data = 32'h1234_5678;
      step(4'b0010, 1'b1, 1'b1, 4'b0000, 1'b1, 32'h200, 32'h0, 1'b0, "fl_wr");
      idle(1);

      // Flush landing exactly on the retiring cycle of a read
      step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h48, 32'h0, 1'b0, "fl2_rd");
      idle(LAT - 1);
      step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0, "fl2_only");
      idle(LAT + 1);

      // The store made during the flush is visible; scan starts at port 3 and wraps to 0
      rd_req_addr[0] = 32'h200;
      step(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h200, 32'h1234_5678, 1'b1, "rd_flushwr");
      idle(LAT + 1);

      // Continuous store stream against a waiting reader on port 0
      wr_req_addr = 32'h300;
      wr_req_data = 32'hA5A5_0000;
      for (int k = 0; k < 10; k++) begin
`ifdef ARB_FAIRNESS_EN
         if (k % 5 == 4)
            step(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 32'h200, 32'h1234_5678, 1'b1, "fair_rd");
         else
            step(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h300, 32'h0, 1'b0, "fair_wr");
`else
         step(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h300, 32'h0, 1'b0, "strict_wr");
`endif
      end
      idle(LAT + 1);

      // Back-to-back reads overlapping with retiring ones; pointer at 1
      step(4'b0111, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h44, 32'h45, 1'b1, "b2b1");
      step(4'b0111, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h48, 32'h49, 1'b1, "b2b2");
      step(4'b0111, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h200, 32'h1234_5678, 1'b1, "b2b3");
      idle(LAT + 1);

      // Reset while a read is outstanding: its response must never appear
      step(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h44, 32'h0, 1'b0, "rst_rd");
      @(negedge clk);
      reset        = 1'b0;
      rd_req_valid = 4'b1111;
      wr_req_valid = 1'b1;
      reset_checks(2);
      @(negedge clk);
      rd_req_valid = 4'b0000;
      wr_req_valid = 1'b0;
      reset        = 1'b1;
      idle(LAT + 2);

      // Pointer returned to 0 by the reset
      step(4'b1010, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h44, 32'h45, 1'b1, "rr_after_rst");
      idle(LAT + 2);

      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
